pseudo_softmax_vec: RTL and testbench

- Parametrised successor to the single-sample pseudo_softmax. Accepts a vector of N unsigned scores over a valid/ready stream and buffers it.
- Computes a base-2 pseudo-softmax of the vector. Each element is emitted as a negative power-of-two exponent plus a mantissa correction, with valid/ready backpressure.
- Sits between the input pins/bus and downstream display or accumulation logic inside the TT wrapper.

---
 rtl/pseudo_softmax_vec_if.sv | 31 +++
 rtl/pseudo_softmax_vec.sv | 139 +++++++++++++
 tb/tb_pseudo_softmax_vec.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pseudo_softmax_vec_if.sv
// Stream interface for pseudo_softmax_vec. It carries the score input stream
// and the (exponent, mantissa) output stream, each with valid/ready.
interface pseudo_softmax_vec_if #(
  parameter int N  = 4,
  parameter int W  = 3,
  parameter int EW = 4,
  parameter int MB = 3
);
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] out_exp;
  logic [MB-1:0] out_mant;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_exp, out_mant, out_index, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_exp, out_mant, out_index, out_last, busy
  );
endinterface

// File: rtl/pseudo_softmax_vec.sv
// Base-2 pseudo-softmax over a vector of N unsigned scores.
// LOAD buffers the vector and tracks its maximum. SUM accumulates
// 2^-(max-x_i) in fixed point. NORM extracts the leading-one position and
// the mantissa of the sum. EMIT streams y_i ~= 2^-e * (1 + mant/2^MB).
module pseudo_softmax_vec #(
  parameter int N    = 4,
  parameter int W    = 3,
  parameter int EW   = 4,
  parameter int MB   = 3,
  parameter int FRAC = 8
) (
  input logic                clk,
  input logic                rst_n,
  pseudo_softmax_vec_if.slave bus
);
  localparam int IW  = $clog2(N);
  localparam int SW  = FRAC + 1 + IW;   // sum width, wide enough for N * 1.0
  localparam int LW  = $clog2(SW);      // leading-one position width
  localparam int EXW = W + IW + 1;      // unsaturated exponent width

  typedef enum logic [1:0] {LOAD, SUM, NORM, EMIT} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  cnt;
  logic [W-1:0]   max_q;
  logic [SW-1:0]  sum_q;
  logic [W-1:0]   vbuf [N];
  logic [EXW-1:0] l_q;
  logic [MB-1:0]  f_q;

  logic           accept;
  logic           last_cnt;
  logic [W-1:0]   d_cur;
  logic [SW-1:0]  term;
  logic [LW-1:0]  lead;
  logic [SW-1:0]  norm;
  logic [MB-1:0]  f_nxt;
  logic [EXW-1:0] l_nxt;
  logic [EXW-1:0] e_full;
  logic [EW-1:0]  e_out;
  logic [MB-1:0]  m_out;

  assign accept   = bus.in_valid && (state == LOAD);
  assign last_cnt = (cnt == IW'(N - 1));
  assign d_cur    = max_q - vbuf[cnt];

  // Next-state logic: sequence LOAD -> SUM -> NORM -> EMIT -> LOAD.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && last_cnt) state_nxt = SUM;
      SUM:  if (last_cnt) state_nxt = NORM;
      NORM: state_nxt = EMIT;
      EMIT: if (bus.out_ready && last_cnt) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Fixed-point term 2^-d for the SUM phase; vanishes once d exceeds FRAC.
  always_comb begin
    term = '0;
    if (int'(d_cur) <= FRAC) term = (SW'(1) << FRAC) >> d_cur;
  end

  // Leading one of the sum, and the MB bits just below it (truncated).
  always_comb begin
    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum_q[i]) lead = LW'(i);
    end
    norm  = sum_q >> (lead - LW'(FRAC));
    f_nxt = MB'(norm >> (FRAC - MB));
    l_nxt = EXW'(int'(lead) - FRAC);
  end

  // Per-element exponent and mantissa, saturated to the output range.
  always_comb begin
    e_full = EXW'(d_cur) + l_q + EXW'(f_q != '0);
    e_out  = EW'(e_full);
    m_out  = (f_q == '0) ? '0 : MB'(0) - f_q;
    if (int'(e_full) > (2 ** EW) - 1) begin
      e_out = '1;
      m_out = '0;
    end
  end

  // Datapath registers: buffer, max, sum, normalisation results and element counter.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      max_q <= '0;
      sum_q <= '0;
      l_q   <= '0;
      f_q   <= '0;
      // NOTE: the score buffer is small, so it is cleared on reset like any register.
      for (int i = 0; i < N; i++) vbuf[i] <= '0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          vbuf[cnt] <= bus.in_data;
          if (cnt == '0 || bus.in_data > max_q) max_q <= bus.in_data;
          cnt <= last_cnt ? '0 : cnt + IW'(1);
        end
        SUM: begin
          sum_q <= sum_q + term;
          cnt   <= last_cnt ? '0 : cnt + IW'(1);
        end
        NORM: begin
          l_q <= l_nxt;
          f_q <= f_nxt;
        end
        EMIT: if (bus.out_ready) begin
          cnt <= last_cnt ? '0 : cnt + IW'(1);
          if (last_cnt) begin
            sum_q <= '0;
            max_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != LOAD);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_exp   = (state == EMIT) ? e_out : '0;
  assign bus.out_mant  = (state == EMIT) ? m_out : '0;
  assign bus.out_index = (state == EMIT) ? cnt : '0;
  assign bus.out_last  = (state == EMIT) && last_cnt;
endmodule

// File: tb/tb_pseudo_softmax_vec.sv
// Directed bench for pseudo_softmax_vec: reset, nominal vectors, latency,
// backpressure, saturation (W=5 instance), held in_valid and back-to-back.
module tb_pseudo_softmax_vec;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pseudo_softmax_vec_if #(.N(N), .W(3), .EW(4), .MB(3)) a ();
  pseudo_softmax_vec_if #(.N(N), .W(5), .EW(4), .MB(3)) b ();

  pseudo_softmax_vec #(.N(N), .W(3), .EW(4), .MB(3), .FRAC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave));
  pseudo_softmax_vec #(.N(N), .W(5), .EW(4), .MB(3), .FRAC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one vector into instance a; optionally leave in_valid high afterwards.
  task automatic send_a(input int v[N], input bit hold, input int hold_data);
    for (int i = 0; i < N; i++) begin
      int t = 0;
      while (!a.in_ready && t < 100) begin step(); t++; end
      a.in_data  = 3'(v[i]);
      a.in_valid = 1'b1;
      step();
    end
    if (hold) a.in_data = 3'(hold_data);
    else      a.in_valid = 1'b0;
  endtask

  task automatic wait_valid_a(output int n);
    n = 0;
    while (!a.out_valid && n < 50) begin step(); n++; end
  endtask

  // Collect N handshakes from instance a, optionally stalling at one index.
  task automatic collect_a(input int stall_idx, input int stall_len,
                           output int ge[N], output int gm[N], output int gi[N],
                           output int gl[N], output int hs, output bit stable);
    int  t = 0;
    bit  stalled = 0;
    hs = 0;
    stable = 1'b1;
    a.out_ready = 1'b1;
    while (hs < N && t < 200) begin
      if (a.out_valid && int'(a.out_index) == stall_idx && !stalled) begin
        int se = int'(a.out_exp);
        int sm = int'(a.out_mant);
        a.out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          if (int'(a.out_exp) != se || int'(a.out_mant) != sm ||
              int'(a.out_index) != stall_idx || !a.out_valid) stable = 1'b0;
        end
        a.out_ready = 1'b1;
        stalled = 1;
      end
      if (a.out_valid && a.out_ready) begin
        ge[hs] = int'(a.out_exp);
        gm[hs] = int'(a.out_mant);
        gi[hs] = int'(a.out_index);
        gl[hs] = int'(a.out_last);
        hs++;
      end
      step();
      t++;
    end
  endtask

  task automatic check_vec(input string name, input int ge[N], input int gm[N],
                           input int gi[N], input int gl[N], input int hs,
                           input int xe[N], input int xm[N]);
    checks++;
    if (hs !== N) begin
      errors++;
      $display("FAIL %s handshakes: got %0d want %0d", name, hs, N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (ge[i] !== xe[i] || gm[i] !== xm[i] || gi[i] !== i || gl[i] !== int'(i == N - 1)) begin
        errors++;
        $display("FAIL %s elem %0d: got e=%0d m=%0d idx=%0d last=%0d want e=%0d m=%0d idx=%0d last=%0d",
                 name, i, ge[i], gm[i], gi[i], gl[i], xe[i], xm[i], i, int'(i == N - 1));
      end
    end
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s return to load: got out_valid=%b in_ready=%b want 0 1",
               name, a.out_valid, a.in_ready);
    end
  endtask

  task automatic test_reset();
    int v[N] = '{3, 3, 3, 3};
    int xe[N] = '{2, 2, 2, 2};
    int xm[N] = '{0, 0, 0, 0};
    int ge[N], gm[N], gi[N], gl[N];
    int hs, n;
    bit st;
    checks++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || a.out_exp !== 4'd0 || a.out_mant !== 3'd0 ||
        a.out_index !== 2'd0 || a.out_last !== 1'b0 || a.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset values: got rdy=%b vld=%b e=%0d m=%0d idx=%0d last=%b busy=%b want 1 0 0 0 0 0 0",
               a.in_ready, a.out_valid, a.out_exp, a.out_mant, a.out_index, a.out_last, a.busy);
    end
    checks++;
    if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset b: got rdy=%b vld=%b want 1 0", b.in_ready, b.out_valid);
    end
    // Abort in the middle of EMIT.
    send_a(v, 1'b0, 0);
    wait_valid_a(n);
    a.out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1 || a.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset in emit: got vld=%b rdy=%b busy=%b want 0 1 0",
               a.out_valid, a.in_ready, a.busy);
    end
    step();
    rst_n = 1'b1;
    step();
    send_a(v, 1'b0, 0);
    wait_valid_a(n);
    collect_a(-1, 0, ge, gm, gi, gl, hs, st);
    check_vec("after_reset", ge, gm, gi, gl, hs, xe, xm);
  endtask

  task automatic test_main();
    int v[N] = '{7, 6, 0, 0};
    int xe[N] = '{1, 2, 8, 8};
    int xm[N] = '{4, 4, 4, 4};
    int ge[N], gm[N], gi[N], gl[N];
    int hs, n;
    bit st;
    send_a(v, 1'b0, 0);
    wait_valid_a(n);
    checks++;
    if (n !== N + 1) begin
      errors++;
      $display("FAIL latency: got %0d edges after accept edge want %0d", n, N + 1);
    end
    collect_a(-1, 0, ge, gm, gi, gl, hs, st);
    check_vec("vec_7600", ge, gm, gi, gl, hs, xe, xm);
  endtask

  task automatic test_second();
    int v[N] = '{5, 5, 5, 2};
    int xe[N] = '{2, 2, 2, 5};
    int xm[N] = '{4, 4, 4, 4};
    int ge[N], gm[N], gi[N], gl[N];
    int hs, n;
    bit st;
    send_a(v, 1'b0, 0);
    wait_valid_a(n);
    collect_a(-1, 0, ge, gm, gi, gl, hs, st);
    check_vec("vec_5552", ge, gm, gi, gl, hs, xe, xm);
  endtask

  task automatic test_backpressure();
    int v[N] = '{7, 6, 0, 0};
    int xe[N] = '{1, 2, 8, 8};
    int xm[N] = '{4, 4, 4, 4};
    int ge[N], gm[N], gi[N], gl[N];
    int hs, n;
    bit st;
    send_a(v, 1'b0, 0);
    wait_valid_a(n);
    collect_a(1, 5, ge, gm, gi, gl, hs, st);
    checks++;
    if (st !== 1'b1) begin
      errors++;
      $display("FAIL stall stable: outputs changed during out_ready=0 (got %b want 1)", st);
    end
    check_vec("backpressure", ge, gm, gi, gl, hs, xe, xm);
  endtask

  task automatic test_saturation();
    int v[N] = '{31, 0, 0, 0};
    int xe[N] = '{0, 15, 15, 15};
    int hs = 0;
    int t = 0;
    for (int i = 0; i < N; i++) begin
      b.in_data  = 5'(v[i]);
      b.in_valid = 1'b1;
      step();
    end
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    while (hs < N && t < 100) begin
      if (b.out_valid) begin
        checks++;
        if (int'(b.out_exp) !== xe[hs] || b.out_mant !== 3'd0 || int'(b.out_index) !== hs) begin
          errors++;
          $display("FAIL saturation elem %0d: got e=%0d m=%0d idx=%0d want e=%0d m=0 idx=%0d",
                   hs, b.out_exp, b.out_mant, b.out_index, xe[hs], hs);
        end
        hs++;
      end
      step();
      t++;
    end
    checks++;
    if (hs !== N) begin
      errors++;
      $display("FAIL saturation handshakes: got %0d want %0d", hs, N);
    end
  endtask

  task automatic test_back_to_back();
    int v1[N] = '{3, 3, 3, 3};
    int v2[N] = '{7, 6, 0, 0};
    int xe1[N] = '{2, 2, 2, 2};
    int xm1[N] = '{0, 0, 0, 0};
    int xe2[N] = '{1, 2, 8, 8};
    int xm2[N] = '{4, 4, 4, 4};
    int ge[N], gm[N], gi[N], gl[N];
    int hs, n;
    bit st;
    // in_valid stays high with a data value that would corrupt the result if stored.
    send_a(v1, 1'b1, 7);
    wait_valid_a(n);
    collect_a(-1, 0, ge, gm, gi, gl, hs, st);
    check_vec("held_valid", ge, gm, gi, gl, hs, xe1, xm1);
    send_a(v2, 1'b0, 0);
    wait_valid_a(n);
    collect_a(-1, 0, ge, gm, gi, gl, hs, st);
    check_vec("back_to_back", ge, gm, gi, gl, hs, xe2, xm2);
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_main();
    test_second();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
